md_ctrl: RTL and testbench
==========================

MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 SHALL have the following ports, clock and reset first:
- clk  in  1  single system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low reset
- ex_valid  in  1  E-stage instruction valid
- ex_op  in  4  E-stage multiply/divide class code (md_pkg)
- ex_a  in  32  rs operand
- ex_b  in  32  rt operand
- flush  in  1  kill the E-stage instruction this cycle
- md_busy  in  1  Busy from the multiply/divide unit
- md_hi  in  32  HI from the multiply/divide unit
- md_lo  in  32  LO from the multiply/divide unit
- md_start  out  1  one-cycle start pulse to the unit
- md_op  out  4  op code to the unit
- md_a  out  32  operand A to the unit
- md_b  out  32  operand B to the unit
- stall  out  1  freeze F/D/E stages
- rd_data  out  32  mfhi/mflo result to E-stage forwarding
- err_timeout  out  1  sticky watchdog error flag
REQ-002 SHALL take its op codes from md_pkg: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8; codes 9-15 are treated as NOP.

Function
REQ-003 SHALL implement three states: IDLE, ARM, WAIT.
REQ-004 SHALL, in IDLE with ex_valid=1, flush=0, md_busy=0 and ex_op in {1,2,3,4,7,8}, assert md_start for exactly that cycle, drive md_op=ex_op, md_a=ex_a, md_b=ex_b, and go to ARM.
REQ-005 SHALL register md_op, md_a and md_b and hold them stable from the start cycle until the controller returns to IDLE.
REQ-006 SHALL leave ARM unconditionally after one cycle: go to WAIT if md_busy=1, otherwise go to IDLE. Ops 7/8 that never raise Busy therefore return to IDLE after ARM.
REQ-007 SHALL remain in WAIT while md_busy=1, and go to IDLE on the first cycle in which md_busy=0.
REQ-008 SHALL assert stall combinationally whenever ex_valid=1, flush=0, ex_op is in 1..8, and either the state is not IDLE or md_busy=1.
REQ-009 SHALL not stall the start cycle itself; the issuing instruction advances.
REQ-010 SHALL drive rd_data=md_hi for MFHI and md_lo for MFLO when not stalled, and 0 otherwise.
REQ-011 SHALL suppress md_start on a cycle with flush=1; flush SHALL NOT abort an operation already in ARM or WAIT.
REQ-012 SHALL never issue a second md_start before returning to IDLE, including back-to-back MD ops, which stall until then.
REQ-013 SHALL hold md_start=0 for ex_op NOP or codes 9-15, and SHALL not assert stall for them.
REQ-014 SHALL keep a 7-bit watchdog counter: clear it on entering WAIT, increment it each WAIT cycle, and saturate at 127.
REQ-015 SHALL set err_timeout when the watchdog counter reaches 64; err_timeout is sticky until reset, and the FSM keeps waiting on md_busy.
REQ-016 SHALL not interpret operands; division by zero is passed through to the unit unchanged.

Reset
REQ-017 SHALL, while reset=0, force state IDLE, watchdog=0, md_start=0, md_op=0, md_a=0, md_b=0 and err_timeout=0, asynchronously.
REQ-018 SHALL, on reset asserted mid-operation, drop to IDLE immediately; the first start after reset release waits for md_busy=0.

Structure
REQ-019 SHALL place the op-code constants, state encoding and WD_LIMIT=64 in the shared package md_pkg.
REQ-020 SHALL be a single module with no sub-modules; the watchdog counter is inline.

Verification
REQ-021 Bench SHALL pair md_ctrl with the existing mult unit and cover at least these directed cases:
- MULT with ex_a=108, ex_b=-20 -> one md_start pulse; stall during Busy; a following MFLO returns 0xFFFFF790 and MFHI returns 0xFFFFFFFF.
- MULT followed immediately by DIVU 7/2 -> DIVU stalls until IDLE, then exactly one start; LO=3, HI=1.
- MTHI 0x12345678 then MFHI -> rd_data=0x12345678 with no lingering stall.
- MULT with flush=1 on the start cycle -> no md_start and no stall; a flush during WAIT does not change state.
- md_busy forced high for 70 cycles -> err_timeout rises at WAIT cycle 64, stays high after Busy falls, and clears only on reset=0.
- reset=0 pulsed during WAIT -> all outputs 0 asynchronously and state IDLE; next op starts only once md_busy=0.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide issue controller:
// op-class codes, controller state encoding and watchdog limits.
package md_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [6:0] WD_LIMIT = 7'd64;
    localparam logic [6:0] WD_MAX   = 7'd127;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_WAIT = 2'd2
    } md_state_e;

    // Ops that hand work to the unit and therefore need a start pulse.
    function automatic logic op_issues(input logic [3:0] op);
        logic r;
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO: r = 1'b1;
            default:                                             r = 1'b0;
        endcase
        return r;
    endfunction

    // Any op that touches HI/LO or the unit and must wait for it.
    function automatic logic op_is_md(input logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_MTLO);
    endfunction

endpackage

// File: rtl/md_ctrl.sv
// E-stage controller for the multiply/divide unit: issues start pulses,
// stalls dependent instructions while the unit works, and watches for hangs.
module md_ctrl
    import md_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [3:0]  ex_op,
    input  logic [31:0] ex_a,
    input  logic [31:0] ex_b,
    input  logic        flush,
    input  logic        md_busy,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    output logic        md_start,
    output logic [3:0]  md_op,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        stall,
    output logic [31:0] rd_data,
    output logic        err_timeout
);

    md_state_e   state_q, state_d;
    logic [6:0]  wd_q, wd_d;
    logic        err_q, err_d;
    logic [3:0]  md_op_q, md_op_d;
    logic [31:0] md_a_q, md_a_d;
    logic [31:0] md_b_q, md_b_d;
    logic        start_s;
    logic        stall_s;
    logic [31:0] rd_s;

    // Next-state, watchdog and operand-capture logic.
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        md_op_d = md_op_q;
        md_a_d  = md_a_q;
        md_b_d  = md_b_q;
        start_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // reset gates the pulse so it stays low while reset is held
                if (reset && ex_valid && !flush && !md_busy && op_issues(ex_op)) begin
                    start_s = 1'b1;
                    state_d = ST_ARM;
                    md_op_d = ex_op;
                    md_a_d  = ex_a;
                    md_b_d  = ex_b;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (md_busy) begin
                    state_d = ST_WAIT;
                    wd_d    = 7'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wd_q != WD_MAX) begin
                    wd_d = wd_q + 7'd1;
                end else begin
                    wd_d = wd_q;
                end
                if (md_busy) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        err_d = err_q | (wd_d == WD_LIMIT);
    end

    // Pipeline-facing stall and HI/LO read-back.
    always_comb begin
        stall_s = 1'b0;
        rd_s    = 32'd0;
        if (ex_valid && !flush && op_is_md(ex_op) &&
            ((state_q != ST_IDLE) || md_busy)) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
        if (ex_valid && !stall_s && (ex_op == OP_MFHI)) begin
            rd_s = md_hi;
        end else if (ex_valid && !stall_s && (ex_op == OP_MFLO)) begin
            rd_s = md_lo;
        end else begin
            rd_s = 32'd0;
        end
    end

    // State, watchdog and operand registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            wd_q    <= 7'd0;
            err_q   <= 1'b0;
            md_op_q <= 4'd0;
            md_a_q  <= 32'd0;
            md_b_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            md_op_q <= md_op_d;
            md_a_q  <= md_a_d;
            md_b_q  <= md_b_d;
        end
    end

    // The start cycle presents the live operands; afterwards the captured copy.
    assign md_start    = start_s;
    assign md_op       = start_s ? ex_op : md_op_q;
    assign md_a        = start_s ? ex_a  : md_a_q;
    assign md_b        = start_s ? ex_b  : md_b_q;
    assign stall       = stall_s;
    assign rd_data     = rd_s;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Scoreboard bench for md_ctrl paired with a behavioural multiply/divide unit.
module tb_md_ctrl;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, flush;
    logic [3:0]  ex_op;
    logic [31:0] ex_a, ex_b;
    logic        md_busy;
    logic [31:0] md_hi, md_lo;
    logic        md_start, stall, err_timeout;
    logic [3:0]  md_op;
    logic [31:0] md_a, md_b, rd_data;

    md_ctrl dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op),
        .ex_a(ex_a), .ex_b(ex_b), .flush(flush), .md_busy(md_busy),
        .md_hi(md_hi), .md_lo(md_lo), .md_start(md_start), .md_op(md_op),
        .md_a(md_a), .md_b(md_b), .stall(stall), .rd_data(rd_data),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Architectural result of one op given the current HI/LO.
    function automatic logic [63:0] md_calc(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] hi,
                                            input logic [31:0] lo);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd1: p = sa * sb;
            4'd2: p = {32'd0, a} * {32'd0, b};
            4'd3: begin
                if (b == 32'd0) p = {a, 32'hFFFFFFFF};
                else begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
            end
            4'd4: begin
                if (b == 32'd0) p = {a, 32'hFFFFFFFF};
                else p = {a % b, a / b};
            end
            4'd7: p = {a, lo};
            4'd8: p = {hi, a};
            default: p = {hi, lo};
        endcase
        return p;
    endfunction

    // ---------------- behavioural multiply/divide unit ----------------
    logic        u_busy = 1'b0;
    logic        force_busy = 1'b0;
    logic [31:0] u_hi = 32'd0, u_lo = 32'd0, u_a = 32'd0, u_b = 32'd0;
    logic [3:0]  u_op = 4'd0;
    int          u_cnt = 0;
    int          lat_fix = 0;
    assign md_busy = u_busy | force_busy;
    assign md_hi   = u_hi;
    assign md_lo   = u_lo;

    always @(posedge clk) begin
        if (md_start) begin
            if (md_op == OP_MTHI) u_hi <= md_a;
            else if (md_op == OP_MTLO) u_lo <= md_a;
            else if (md_op >= OP_MULT && md_op <= OP_DIVU) begin
                u_busy <= 1'b1;
                u_cnt  <= (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 6));
                u_op   <= md_op;
                u_a    <= md_a;
                u_b    <= md_b;
            end
        end else if (u_busy) begin
            if (u_cnt <= 1) begin
                u_busy <= 1'b0;
                {u_hi, u_lo} <= md_calc(u_op, u_a, u_b, u_hi, u_lo);
            end else begin
                u_cnt <= u_cnt - 1;
            end
        end
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } start_t;
    start_t      start_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] hi_m = 32'd0, lo_m = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    // Present one instruction, hold it while stalled, and record what it must cause.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic fl, input bit use_exp, input logic [31:0] exp_v,
                         output int stalls);
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_op = op; ex_a = a; ex_b = b; flush = fl;
        stalls = 0;
        @(negedge clk);
        while (stall && stalls < 300) begin
            stalls++;
            @(negedge clk);
        end
        if (stall) begin
            check("issue_timeout", 64'd1, 64'd0);
        end else if (!fl) begin
            if (op_issues(op)) begin
                start_q.push_back('{op, a, b});
                {hi_m, lo_m} = md_calc(op, a, b, hi_m, lo_m);
            end else if (op == OP_MFHI) begin
                rd_q.push_back(use_exp ? exp_v : hi_m);
            end else if (op == OP_MFLO) begin
                rd_q.push_back(use_exp ? exp_v : lo_m);
            end
        end
    endtask

    task automatic bubble(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            ex_valid = 1'b0; flush = 1'b0; ex_op = OP_NOP;
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    start_t held;
    logic   held_v = 1'b0;
    always begin
        start_t e;
        @(negedge clk); #1;
        if (!reset) begin
            held_v = 1'b0;
        end else begin
            if (md_start) begin
                check("start_not_stalled", stall, 0);
                check("start_unit_idle", md_busy, 0);
                if (start_q.size() == 0) begin
                    check("start_unexpected", 64'd1, 64'd0);
                end else begin
                    e = start_q.pop_front();
                    check("md_op", md_op, e.op);
                    check("md_a", md_a, e.a);
                    check("md_b", md_b, e.b);
                end
                held   = '{md_op, md_a, md_b};
                held_v = 1'b1;
            end else if (md_busy && held_v) begin
                check("hold_op", md_op, held.op);
                check("hold_a", md_a, held.a);
                check("hold_b", md_b, held.b);
            end
            if (ex_valid && !flush) begin
                if (op_is_md(ex_op) && md_busy) check("stall_busy", stall, 1);
                if (!op_is_md(ex_op)) check("stall_nop", stall, 0);
                if ((ex_op == OP_MFHI || ex_op == OP_MFLO) && !stall) begin
                    if (rd_q.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
                    else check("rd_data", rd_data, rd_q.pop_front());
                end else begin
                    check("rd_zero", rd_data, 0);
                end
            end else if (!ex_valid) begin
                check("rd_idle", rd_data, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int s;
        int c0;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic        fl;

        reset = 1'b0; ex_valid = 1'b0; flush = 1'b0; ex_op = OP_NOP;
        ex_a = 32'd0; ex_b = 32'd0;
        #2;
        check("rst_start", md_start, 0);
        check("rst_op", md_op, 0);
        check("rst_a", md_a, 0);
        check("rst_b", md_b, 0);
        check("rst_err", err_timeout, 0);
        check("rst_stall", stall, 0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;

        // MULT 108 * -20, then read LO/HI.
        lat_fix = 5;
        issue(OP_MULT, 32'd108, 32'hFFFFFFEC, 1'b0, 1'b0, 32'd0, s);
        issue(OP_MFLO, 32'd0, 32'd0, 1'b0, 1'b1, 32'hFFFFF790, s);
        check("mflo_waited", s > 0, 1);
        issue(OP_MFHI, 32'd0, 32'd0, 1'b0, 1'b1, 32'hFFFFFFFF, s);
        bubble(2);

        // Back-to-back MULT then DIVU 7/2.
        issue(OP_MULT, 32'd3, 32'd5, 1'b0, 1'b0, 32'd0, s);
        issue(OP_DIVU, 32'd7, 32'd2, 1'b0, 1'b0, 32'd0, s);
        check("divu_waited", s > 0, 1);
        issue(OP_MFLO, 32'd0, 32'd0, 1'b0, 1'b1, 32'd3, s);
        issue(OP_MFHI, 32'd0, 32'd0, 1'b0, 1'b1, 32'd1, s);
        bubble(2);

        // MTHI then MFHI: only the single ARM cycle may stall.
        issue(OP_MTHI, 32'h12345678, 32'd0, 1'b0, 1'b0, 32'd0, s);
        issue(OP_MFHI, 32'd0, 32'd0, 1'b0, 1'b1, 32'h12345678, s);
        check("mfhi_after_mthi_stalls", s, 1);
        bubble(2);

        // Flushed start, then a flush arriving while the unit works.
        issue(OP_MULT, 32'd9, 32'd9, 1'b1, 1'b0, 32'd0, s);
        check("flushed_no_stall", s, 0);
        lat_fix = 10;
        issue(OP_MULT, 32'd6, 32'd7, 1'b0, 1'b0, 32'd0, s);
        bubble(3);
        issue(OP_DIVU, 32'd1, 32'd1, 1'b1, 1'b0, 32'd0, s);
        check("flush_in_wait_no_stall", s, 0);
        issue(OP_MFLO, 32'd0, 32'd0, 1'b0, 1'b1, 32'd42, s);
        check("mflo_after_flush_waited", s > 0, 1);
        bubble(2);

        // Reset in the middle of WAIT.
        lat_fix = 20;
        issue(OP_MULT, 32'd9, 32'd11, 1'b0, 1'b0, 32'd0, s);
        bubble(5);
        @(posedge clk); #2 reset = 1'b0;
        #1;
        check("midrst_start", md_start, 0);
        check("midrst_op", md_op, 0);
        check("midrst_a", md_a, 0);
        check("midrst_b", md_b, 0);
        check("midrst_err", err_timeout, 0);
        check("midrst_stall", stall, 0);
        check("midrst_rd", rd_data, 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #2 reset = 1'b1;
        issue(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0, s);
        check("post_reset_waits_busy", s > 0, 1);
        issue(OP_MFLO, 32'd0, 32'd0, 1'b0, 1'b1, 32'd14, s);
        issue(OP_MFHI, 32'd0, 32'd0, 1'b0, 1'b1, 32'd2, s);
        bubble(2);

        // Randomized instruction stream.
        lat_fix = 0;
        for (int i = 0; i < 250; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom();
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 9));
            fl = (op != OP_MFHI) && (op != OP_MFLO) && ($urandom_range(0, 9) == 0);
            issue(op, a, b, fl, 1'b0, 32'd0, s);
            if ($urandom_range(0, 3) == 0) bubble(int'($urandom_range(1, 2)));
        end
        bubble(10);

        // Watchdog: Busy held high long past the limit.
        lat_fix = 3;
        issue(OP_MULT, 32'd2, 32'd3, 1'b0, 1'b0, 32'd0, s);
        c0 = cyc;
        bubble(1);
        force_busy = 1'b1;
        while (cyc != c0 + 65) @(negedge clk);
        #2 check("err_before_limit", err_timeout, 0);
        @(negedge clk);
        #2 check("err_at_limit", err_timeout, 1);
        repeat (5) @(negedge clk);
        @(posedge clk); #1 force_busy = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("err_sticky", err_timeout, 1);
        issue(OP_MFLO, 32'd0, 32'd0, 1'b0, 1'b1, 32'd6, s);
        check("idle_after_timeout", s, 0);
        bubble(2);
        @(posedge clk); #2 reset = 1'b0;
        #1 check("err_cleared_by_reset", err_timeout, 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #2 reset = 1'b1;
        bubble(5);

        check("start_queue_drained", start_q.size(), 0);
        check("rd_queue_drained", rd_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
